// File: rtl/insn_packer.sv
// Instruction packer: encodes decoded instructions into the left/right halves
// of a 64-bit micro-BESM instruction word and emits words over valid/ready.
module insn_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_pe,
  input  logic [3:0]  in_ir,
  input  logic [7:0]  in_op,
  input  logic        in_extop,
  input  logic [19:0] in_addr,
  input  logic        drain,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_word,
  output logic        out_single,
  output logic        err
);

  typedef enum logic {S_EMPTY, S_HALF} state_e;

  state_e      state_q, state_d;
  logic [31:0] left_q, left_d;
  logic        mode_q, mode_d;
  logic [63:0] word_q, word_d;
  logic        single_q, single_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;

  logic        slot_free, hs, bad, load, drain_go;
  logic [31:0] enc_left, enc_right;

  assign in_ready   = slot_free;
  assign out_valid  = valid_q;
  assign out_word   = word_q;
  assign out_single = single_q;
  assign err        = err_q;

  always_comb begin
    slot_free = !valid_q | out_ready;
    hs        = in_valid & slot_free;
    drain_go  = !hs & drain & slot_free & (state_q == S_HALF);
    if (!in_pe) begin
      bad = !in_extop && (in_op == 8'h3f);
    end else if (in_extop) begin
      bad = 1'b1;
    end else if (in_op[7]) begin
      bad = (in_op[2:0] != 3'd0) || (in_addr[19:15] != 5'd0);
    end else begin
      bad = (in_addr[19:15] != 5'd0) || (in_addr[14:12] != {3{in_op[6]}});
    end
  end

  // BESM-6 right halves put ir into the low nibble of L; that nibble is zero
  // in every BESM-6 left encoding, so it is spliced in when the pair completes.
  always_comb begin
    enc_left  = '0;
    enc_right = '0;
    if (!in_pe) begin
      enc_left  = in_extop ? {in_ir, 8'h3f, in_op, in_addr[11:0]} : {in_ir, in_op, in_addr};
      enc_right = enc_left;
    end else begin
      enc_left[31]    = in_ir[3];
      enc_left[26:24] = in_ir[2:0];
      if (in_op[7]) begin
        enc_left[23:19]  = in_op[7:3];
        enc_left[18:4]   = in_addr[14:0];
        enc_right[31:27] = in_op[7:3];
        enc_right[26:12] = in_addr[14:0];
      end else begin
        enc_left[23:16]  = in_op;
        enc_left[15:4]   = in_addr[11:0];
        enc_right[31:24] = in_op;
        enc_right[23:12] = in_addr[11:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_EMPTY: if (hs && !bad) state_d = S_HALF;
      S_HALF: begin
        if (hs && !bad && (in_pe == mode_q)) state_d = S_EMPTY;
        else if (drain_go)                   state_d = S_EMPTY;
      end
    endcase
  end

  always_comb begin
    left_d   = left_q;
    mode_d   = mode_q;
    word_d   = word_q;
    single_d = single_q;
    load     = 1'b0;
    err_d    = hs & bad;
    if (hs && !bad) begin
      if (state_q == S_EMPTY) begin
        left_d = enc_left;
        mode_d = in_pe;
      end else if (in_pe == mode_q) begin
        load     = 1'b1;
        word_d   = mode_q ? {left_q[31:4], in_ir, enc_right} : {left_q, enc_right};
        single_d = 1'b0;
        left_d   = '0;
      end else begin
        load     = 1'b1;
        word_d   = {left_q, 32'h0};
        single_d = 1'b1;
        left_d   = enc_left;
        mode_d   = in_pe;
      end
    end else if (drain_go) begin
      load     = 1'b1;
      word_d   = {left_q, 32'h0};
      single_d = 1'b1;
      left_d   = '0;
    end
    valid_d = load | (valid_q & !out_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      left_q   <= '0;
      mode_q   <= 1'b0;
      word_q   <= '0;
      single_q <= 1'b0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      left_q   <= left_d;
      mode_q   <= mode_d;
      word_q   <= word_d;
      single_q <= single_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_insn_packer.sv
// Self-checking bench for insn_packer: a dc[64:1] reference model feeds a
// scoreboard of expected words, plus directed checks of the worked examples.
module tb_insn_packer;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_pe, in_extop, drain;
  logic [3:0]  in_ir;
  logic [7:0]  in_op;
  logic [19:0] in_addr;
  logic        out_valid, out_ready, out_single, err;
  logic [63:0] out_word;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] w;
    logic        s;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  logic [64:1] m_dc;
  bit          m_half = 0;
  bit          m_pe = 0;

  insn_packer dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_pe(in_pe), .in_ir(in_ir), .in_op(in_op), .in_extop(in_extop),
    .in_addr(in_addr), .drain(drain), .out_valid(out_valid),
    .out_ready(out_ready), .out_word(out_word), .out_single(out_single),
    .err(err)
  );

  always #5 clk = ~clk;

  function automatic bit m_bad(input logic pe, input logic [7:0] op,
                               input logic extop, input logic [19:0] addr);
    if (!pe) return !extop && op == 8'h3f;
    if (extop) return 1'b1;
    if (op[7]) return (op[2:0] != 3'd0) || (addr[19:15] != 5'd0);
    return (addr[19:15] != 5'd0) || (addr[14:12] != {3{op[6]}});
  endfunction

  task automatic m_place(input bit right, input logic pe, input logic [3:0] ir,
                         input logic [7:0] op, input logic extop, input logic [19:0] addr);
    if (!pe && !right) begin
      m_dc[64:61] = ir;
      if (extop) begin m_dc[60:53] = 8'h3f; m_dc[52:45] = op; m_dc[44:33] = addr[11:0]; end
      else begin m_dc[60:53] = op; m_dc[52:33] = addr; end
    end else if (!pe) begin
      m_dc[32:29] = ir;
      if (extop) begin m_dc[28:21] = 8'h3f; m_dc[20:13] = op; m_dc[12:1] = addr[11:0]; end
      else begin m_dc[28:21] = op; m_dc[20:1] = addr; end
    end else if (!right) begin
      m_dc[64] = ir[3];
      m_dc[59:57] = ir[2:0];
      if (op[7]) begin m_dc[56:52] = op[7:3]; m_dc[51:37] = addr[14:0]; end
      else begin m_dc[56:49] = op; m_dc[48:37] = addr[11:0]; end
    end else begin
      m_dc[36:33] = ir;
      if (op[7]) begin m_dc[32:28] = op[7:3]; m_dc[27:13] = addr[14:0]; end
      else begin m_dc[32:25] = op; m_dc[24:13] = addr[11:0]; end
    end
  endtask

  task automatic m_accept(input logic pe, input logic [3:0] ir, input logic [7:0] op,
                          input logic extop, input logic [19:0] addr);
    exp_t e;
    if (m_bad(pe, op, extop, addr)) return;
    if (!m_half) begin
      m_dc = '0;
      m_place(0, pe, ir, op, extop, addr);
      m_pe = pe;
      m_half = 1;
    end else if (m_pe == pe) begin
      m_place(1, pe, ir, op, extop, addr);
      e.w = m_dc; e.s = 1'b0;
      sbq.push_back(e);
      m_half = 0;
    end else begin
      e.w = {m_dc[64:33], 32'h0}; e.s = 1'b1;
      sbq.push_back(e);
      m_dc = '0;
      m_place(0, pe, ir, op, extop, addr);
      m_pe = pe;
    end
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected got word %h single %b, required no word", out_word, out_single);
      end else begin
        mon_e = sbq.pop_front();
        if (out_word !== mon_e.w || out_single !== mon_e.s) begin
          errors++;
          $display("FAIL sb_word got %h/%b required %h/%b", out_word, out_single, mon_e.w, mon_e.s);
        end
      end
    end
  end

  task automatic send(input logic pe, input logic [3:0] ir, input logic [7:0] op,
                      input logic extop, input logic [19:0] addr);
    bit bad;
    int unsigned n = 0;
    in_valid = 1'b1; in_pe = pe; in_ir = ir; in_op = op; in_extop = extop; in_addr = addr;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout in_ready %b required 1", in_ready);
      in_valid = 1'b0;
      return;
    end
    bad = m_bad(pe, op, extop, addr);
    m_accept(pe, ir, op, extop, addr);
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (err !== bad) begin
      errors++;
      $display("FAIL err_pulse got %b required %b", err, bad);
    end
  endtask

  task automatic do_drain();
    exp_t e;
    int unsigned n = 0;
    drain = 1'b1;
    @(negedge clk);
    while (m_half && !in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (m_half) begin
      if (!in_ready) begin
        checks++; errors++;
        $display("FAIL drain_timeout in_ready %b required 1", in_ready);
      end else begin
        e.w = {m_dc[64:33], 32'h0}; e.s = 1'b1;
        sbq.push_back(e);
        m_half = 0;
      end
    end
    @(posedge clk); #1;
    drain = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; in_pe = 1'b0; in_ir = '0; in_op = '0;
    in_extop = 1'b0; in_addr = '0; drain = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_word !== 64'h0 || out_single !== 1'b0 ||
        err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state got v%b w%h s%b e%b r%b required v0 w0 s0 e0 r1",
               out_valid, out_word, out_single, err, in_ready);
    end
    reset = 1'b0;
  endtask

  task automatic test_native_pair();
    send(1'b0, 4'd3, 8'h12, 1'b0, 20'h12345);
    send(1'b0, 4'd4, 8'h05, 1'b0, 20'h00abc);
    checks++;
    if (out_valid !== 1'b1 || out_word !== 64'h3121_2345_4050_0abc || out_single !== 1'b0) begin
      errors++;
      $display("FAIL native_pair got v%b %h s%b required v1 3121234540500abc s0",
               out_valid, out_word, out_single);
    end
  endtask

  task automatic test_extended();
    send(1'b0, 4'd1, 8'h9a, 1'b1, 20'h00123);
    send(1'b0, 4'd0, 8'h00, 1'b0, 20'h00000);
    checks++;
    if (out_valid !== 1'b1 || out_word[63:32] !== 32'h13f9_a123) begin
      errors++;
      $display("FAIL extended_left got v%b %h required v1 13f9a123", out_valid, out_word[63:32]);
    end
  endtask

  task automatic test_besm6();
    logic [63:0] w;
    send(1'b1, 4'd9, 8'hb8, 1'b0, 20'h07fff);
    send(1'b1, 4'd2, 8'h45, 1'b0, 20'h07123);
    w = out_word;
    checks++;
    if (out_valid !== 1'b1 || w[63] !== 1'b1 || w[58:56] !== 3'd1 || w[55:51] !== 5'h17 ||
        w[50:36] !== 15'h7fff || w[35:32] !== 4'd2 || w[31:24] !== 8'h45 ||
        w[23:12] !== 12'h123 || out_single !== 1'b0) begin
      errors++;
      $display("FAIL besm6_fields got v%b %h required v1 81bffff245123000", out_valid, w);
    end
  endtask

  task automatic test_errors();
    send(1'b0, 4'd1, 8'h3f, 1'b0, 20'h00000);
    send(1'b1, 4'd0, 8'h05, 1'b0, 20'h07000);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL err_no_word got out_valid %b required 0", out_valid);
    end
    send(1'b0, 4'd6, 8'h21, 1'b0, 20'hfedcb);
    send(1'b1, 4'd0, 8'h81, 1'b0, 20'h00000);
    send(1'b0, 4'd7, 8'h3c, 1'b0, 20'h13579);
  endtask

  task automatic test_mode_drain();
    send(1'b0, 4'd7, 8'h55, 1'b0, 20'habcde);
    send(1'b1, 4'd3, 8'h90, 1'b0, 20'h00100);
    checks++;
    if (out_valid !== 1'b1 || out_single !== 1'b1 || out_word !== 64'h755a_bcde_0000_0000) begin
      errors++;
      $display("FAIL mode_switch got v%b %h s%b required v1 755abcde00000000 s1",
               out_valid, out_word, out_single);
    end
    do_drain();
    checks++;
    if (out_valid !== 1'b1 || out_single !== 1'b1 || out_word[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL drain_emit got v%b %h s%b required v1 padded s1", out_valid, out_word, out_single);
    end
    do_drain();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty got out_valid %b required 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(1'b0, 4'd1, 8'h22, 1'b0, 20'h33333);
    send(1'b1, 4'd5, 8'h88, 1'b0, 20'h01234);
    fork
      send(1'b1, 4'd6, 8'h11, 1'b0, 20'h00456);
      begin
        repeat (5) begin
          @(negedge clk);
          checks++;
          if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_word !== 64'h1223_3333_0000_0000) begin
            errors++;
            $display("FAIL stall got r%b v%b %h required r0 v1 1223333300000000",
                     in_ready, out_valid, out_word);
          end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    checks++;
    if (out_valid !== 1'b1 || out_word !== 64'h0589_2346_1145_6000 || out_single !== 1'b0) begin
      errors++;
      $display("FAIL no_bubble got v%b %h s%b required v1 0589234611456000 s0",
               out_valid, out_word, out_single);
    end
  endtask

  task automatic test_reset_mid();
    send(1'b0, 4'd2, 8'h10, 1'b0, 20'h11111);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    m_half = 0;
    sbq.delete();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got out_valid %b required 0", out_valid);
    end
    send(1'b0, 4'ha, 8'h01, 1'b0, 20'h00001);
    send(1'b0, 4'hb, 8'h02, 1'b0, 20'h00002);
    checks++;
    if (out_word !== 64'ha010_0001_b020_0002 || out_single !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_pair got %h s%b required a0100001b0200002 s0", out_word, out_single);
    end
  endtask

  initial begin
    test_reset();
    test_native_pair();
    test_extended();
    test_besm6();
    test_errors();
    test_mode_drain();
    test_backpressure();
    test_reset_mid();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL sb_drained got %0d pending words required 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
